// File: rtl/params_pkg.sv
// Shared widths and types for the multiply/writeback scheduling slice.
package params_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REGISTER_WIDTH = 5;
  localparam int unsigned MUL_LATENCY    = 5;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_MUL,
    WB_BUF,
    WB_ALU
  } wb_src_e;

  typedef struct packed {
    logic                      valid;
    logic [REGISTER_WIDTH-1:0] rd;
  } mul_stage_t;

endpackage

// File: rtl/mul_wb_scheduler_if.sv
// Issue/result bundle between the execute/memory stages and the writeback scheduler.
interface mul_wb_scheduler_if #(
  parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) ();

  logic                      ex_valid;
  logic [REGISTER_WIDTH-1:0] ex_wr_reg;
  logic [DATA_WIDTH-1:0]     mul_result;
  logic                      alu_wb_valid;
  logic [REGISTER_WIDTH-1:0] alu_wb_reg;
  logic [DATA_WIDTH-1:0]     alu_wb_data;
  logic                      alu_wb_ready;

  modport master (
    output ex_valid,
    output ex_wr_reg,
    output mul_result,
    output alu_wb_valid,
    output alu_wb_reg,
    output alu_wb_data,
    input  alu_wb_ready
  );

  modport slave (
    input  ex_valid,
    input  ex_wr_reg,
    input  mul_result,
    input  alu_wb_valid,
    input  alu_wb_reg,
    input  alu_wb_data,
    output alu_wb_ready
  );

endinterface

// File: rtl/wb_hold_buffer.sv
// Single-entry parking slot for an ALU/memory result that lost arbitration to a multiply.
module wb_hold_buffer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REGISTER_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic                      clear_i,
  input  logic [REGISTER_WIDTH-1:0] rd_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic                      valid_o,
  output logic [REGISTER_WIDTH-1:0] rd_o,
  output logic [DATA_WIDTH-1:0]     data_o
);

  logic                      valid_q, valid_d;
  logic [REGISTER_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      rd_d    = rd_i;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mul_wb_scheduler.sv
// Tracks in-flight fixed-latency multiplies and arbitrates the single register-file write port
// between multiply results, a parked ALU result and a fresh ALU result.
module mul_wb_scheduler #(
  parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int unsigned MUL_LATENCY    = params_pkg::MUL_LATENCY,
  parameter int unsigned COLL_CNT_WIDTH = 16
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  mul_wb_scheduler_if.slave                          bus,
  output logic [MUL_LATENCY-2:0]                     ex_valid_o,
  output logic [MUL_LATENCY-2:0][REGISTER_WIDTH-1:0] ex_wr_reg_o,
  output logic                                       wb_is_next_cycle_o,
  output logic                                       wb_reg_wr_en_o,
  output logic [REGISTER_WIDTH-1:0]                  wb_wr_reg_o,
  output logic [DATA_WIDTH-1:0]                      wb_data_o,
  output logic [COLL_CNT_WIDTH-1:0]                  coll_cnt_o
);

  import params_pkg::*;

  localparam int unsigned LastStage = MUL_LATENCY - 1;

  // Index 0 is stage 1; index LastStage is the stage whose result is on mul_result.
  mul_stage_t [MUL_LATENCY-1:0] stage_q, stage_d;

  logic                      hold_valid;
  logic [REGISTER_WIDTH-1:0] hold_rd;
  logic [DATA_WIDTH-1:0]     hold_data;
  logic                      hold_load, hold_clear;

  logic                      alu_ready;
  logic                      alu_take;
  logic                      alu_live;
  mul_stage_t                mul_last;
  wb_src_e                   wb_src;

  logic                      wb_en_q, wb_en_d;
  logic [REGISTER_WIDTH-1:0] wb_reg_q, wb_reg_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [COLL_CNT_WIDTH-1:0] coll_cnt_q, coll_cnt_d;

  // The pipe never stalls; an x0 destination is dropped here so it can never raise a hazard.
  always_comb begin
    stage_d          = stage_q;
    stage_d[0].valid = bus.ex_valid && (bus.ex_wr_reg != '0);
    stage_d[0].rd    = bus.ex_wr_reg;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_comb begin
    ex_valid_o  = '0;
    ex_wr_reg_o = '0;
    for (int k = 0; k < MUL_LATENCY - 1; k++) begin
      ex_valid_o[k]  = stage_q[k].valid;
      ex_wr_reg_o[k] = stage_q[k].rd;
    end
  end

  assign mul_last           = stage_q[LastStage];
  assign wb_is_next_cycle_o = mul_last.valid;

  // Ready comes from the registered buffer flag only, so upstream sees no input-to-ready path.
  assign alu_ready        = !hold_valid;
  assign bus.alu_wb_ready = alu_ready;
  assign alu_take         = bus.alu_wb_valid && alu_ready;
  assign alu_live         = alu_take && (bus.alu_wb_reg != '0);

  always_comb begin
    wb_src = WB_NONE;
    if (mul_last.valid) begin
      wb_src = WB_MUL;
    end else if (hold_valid) begin
      wb_src = WB_BUF;
    end else if (alu_live) begin
      wb_src = WB_ALU;
    end
  end

  assign hold_load  = (wb_src == WB_MUL) && alu_live;
  assign hold_clear = (wb_src == WB_BUF);

  always_comb begin
    wb_en_d   = (wb_src != WB_NONE);
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    unique case (wb_src)
      WB_MUL: begin
        wb_reg_d  = mul_last.rd;
        wb_data_d = bus.mul_result;
      end
      WB_BUF: begin
        wb_reg_d  = hold_rd;
        wb_data_d = hold_data;
      end
      WB_ALU: begin
        wb_reg_d  = bus.alu_wb_reg;
        wb_data_d = bus.alu_wb_data;
      end
      WB_NONE: ;
    endcase
  end

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (hold_load && (coll_cnt_q != '1)) begin
      coll_cnt_d = coll_cnt_q + COLL_CNT_WIDTH'(1);
    end
  end

  wb_hold_buffer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REGISTER_WIDTH(REGISTER_WIDTH)
  ) u_hold (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (hold_load),
    .clear_i(hold_clear),
    .rd_i   (bus.alu_wb_reg),
    .data_i (bus.alu_wb_data),
    .valid_o(hold_valid),
    .rd_o   (hold_rd),
    .data_o (hold_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stage_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      coll_cnt_q <= '0;
    end else begin
      stage_q    <= stage_d;
      wb_en_q    <= wb_en_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign wb_reg_wr_en_o = wb_en_q;
  assign wb_wr_reg_o    = wb_reg_q;
  assign wb_data_o      = wb_data_q;
  assign coll_cnt_o     = coll_cnt_q;

  // A full buffer must hold ready low, so a second deferral can never overwrite it.
  a_no_overwrite : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(hold_load && hold_valid));
  a_no_load_clear : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(hold_load && hold_clear));

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// Directed-vector bench for mul_wb_scheduler with hand-computed expectations.
module tb_mul_wb_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned ML = 5;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  mul_wb_scheduler_if #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW)) bus ();

  logic [ML-2:0]         ex_valid;
  logic [ML-2:0][RW-1:0] ex_wr_reg;
  logic                  wb_next;
  logic                  wr_en;
  logic [RW-1:0]         wr_reg;
  logic [DW-1:0]         wr_data;
  logic [CW-1:0]         coll;

  int n_vec = 0;
  int n_err = 0;

  mul_wb_scheduler #(
    .DATA_WIDTH    (DW),
    .REGISTER_WIDTH(RW),
    .MUL_LATENCY   (ML),
    .COLL_CNT_WIDTH(CW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .bus               (bus),
    .ex_valid_o        (ex_valid),
    .ex_wr_reg_o       (ex_wr_reg),
    .wb_is_next_cycle_o(wb_next),
    .wb_reg_wr_en_o    (wr_en),
    .wb_wr_reg_o       (wr_reg),
    .wb_data_o         (wr_data),
    .coll_cnt_o        (coll)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid     = 1'b0;
    bus.ex_wr_reg    = '0;
    bus.mul_result   = '0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_reg   = '0;
    bus.alu_wb_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b0;
    #22;
    n_vec++;
    if ({ex_valid, wb_next, wr_en} !== '0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0", {ex_valid, wb_next, wr_en});
    end
    n_vec++;
    if (ex_wr_reg !== '0) begin
      n_err++;
      $display("FAIL reset_stage_rd: got %h want 0", ex_wr_reg);
    end
    n_vec++;
    if ({wr_reg, wr_data} !== '0) begin
      n_err++;
      $display("FAIL reset_wb: got %h/%h want 0/0", wr_reg, wr_data);
    end
    n_vec++;
    if (coll !== '0) begin
      n_err++;
      $display("FAIL reset_coll: got %0d want 0", coll);
    end
    n_vec++;
    if (bus.alu_wb_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", bus.alu_wb_ready);
    end
    @(negedge clk);
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_single_mul();
    logic [ML-2:0] exp_v;
    do_reset();
    bus.ex_valid  = 1'b1;
    bus.ex_wr_reg = 5'd5;
    step();
    idle();
    for (int k = 0; k < ML - 1; k++) begin
      exp_v    = '0;
      exp_v[k] = 1'b1;
      n_vec++;
      if (ex_valid !== exp_v || ex_wr_reg[k] !== 5'd5 || wb_next !== 1'b0) begin
        n_err++;
        $display("FAIL single_stage%0d: got v=%b rd=%0d nx=%b want v=%b rd=5 nx=0",
                 k + 1, ex_valid, ex_wr_reg[k], wb_next, exp_v);
      end
      step();
    end
    n_vec++;
    if ({ex_valid, wb_next, wr_en} !== {4'b0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_next: got %b want 000010", {ex_valid, wb_next, wr_en});
    end
    bus.mul_result = 32'h0000_1234;
    step();
    bus.mul_result = '0;
    n_vec++;
    if ({wr_en, wr_reg, wr_data} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      n_err++;
      $display("FAIL single_write: got en=%b rd=%0d d=%h want en=1 rd=5 d=00001234",
               wr_en, wr_reg, wr_data);
    end
    step();
    n_vec++;
    if ({wr_en, wr_reg, wr_data, wb_next} !== {1'b0, 5'd5, 32'h0000_1234, 1'b0}) begin
      n_err++;
      $display("FAIL single_after: got en=%b rd=%0d d=%h nx=%b want en=0 rd=5 d=00001234 nx=0",
               wr_en, wr_reg, wr_data, wb_next);
    end
  endtask

  task automatic test_x0_mul();
    do_reset();
    bus.ex_valid  = 1'b1;
    bus.ex_wr_reg = 5'd0;
    step();
    idle();
    for (int c = 1; c <= 7; c++) begin
      n_vec++;
      if ({ex_valid, wb_next, wr_en} !== '0) begin
        n_err++;
        $display("FAIL x0_mul_c%0d: got %b want 0", c, {ex_valid, wb_next, wr_en});
      end
      step();
    end
  endtask

  task automatic test_alu_direct();
    do_reset();
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_reg   = 5'd9;
    bus.alu_wb_data  = 32'h0000_0055;
    n_vec++;
    if (bus.alu_wb_ready !== 1'b1) begin
      n_err++;
      $display("FAIL alu_ready: got %b want 1", bus.alu_wb_ready);
    end
    step();
    bus.alu_wb_reg  = 5'd0;
    bus.alu_wb_data = 32'h0000_FFFF;
    n_vec++;
    if ({wr_en, wr_reg, wr_data} !== {1'b1, 5'd9, 32'h0000_0055}) begin
      n_err++;
      $display("FAIL alu_direct: got en=%b rd=%0d d=%h want en=1 rd=9 d=00000055",
               wr_en, wr_reg, wr_data);
    end
    step();
    idle();
    n_vec++;
    if ({wr_en, wr_reg, wr_data, bus.alu_wb_ready} !== {1'b0, 5'd9, 32'h0000_0055, 1'b1}) begin
      n_err++;
      $display("FAIL alu_x0: got en=%b rd=%0d d=%h rdy=%b want en=0 rd=9 d=00000055 rdy=1",
               wr_en, wr_reg, wr_data, bus.alu_wb_ready);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.ex_valid  = 1'b1;
    bus.ex_wr_reg = 5'd3;
    step();
    idle();
    repeat (4) step();
    bus.mul_result   = 32'h0000_3333;
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_reg   = 5'd7;
    bus.alu_wb_data  = 32'h0000_AAAA;
    n_vec++;
    if ({wb_next, bus.alu_wb_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL coll_pre: got nx,rdy=%b want 11", {wb_next, bus.alu_wb_ready});
    end
    step();
    idle();
    n_vec++;
    if ({wr_en, wr_reg, wr_data, bus.alu_wb_ready} !== {1'b1, 5'd3, 32'h0000_3333, 1'b0}) begin
      n_err++;
      $display("FAIL coll_mul: got en=%b rd=%0d d=%h rdy=%b want en=1 rd=3 d=00003333 rdy=0",
               wr_en, wr_reg, wr_data, bus.alu_wb_ready);
    end
    n_vec++;
    if (coll !== 3'd1) begin
      n_err++;
      $display("FAIL coll_cnt: got %0d want 1", coll);
    end
    step();
    n_vec++;
    if ({wr_en, wr_reg, wr_data, bus.alu_wb_ready} !== {1'b1, 5'd7, 32'h0000_AAAA, 1'b1}) begin
      n_err++;
      $display("FAIL coll_buf: got en=%b rd=%0d d=%h rdy=%b want en=1 rd=7 d=0000aaaa rdy=1",
               wr_en, wr_reg, wr_data, bus.alu_wb_ready);
    end
    step();
    n_vec++;
    if ({wr_en, coll} !== {1'b0, 3'd1}) begin
      n_err++;
      $display("FAIL coll_after: got en=%b cnt=%0d want en=0 cnt=1", wr_en, coll);
    end
  endtask

  task automatic test_back_to_back();
    logic          exp_rdy;
    logic          exp_en;
    logic [RW-1:0] exp_rd;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      bus.ex_valid     = (c < 3);
      bus.ex_wr_reg    = RW'(10 + c);
      bus.mul_result   = 32'hC0DE_0000 + DW'(c);
      bus.alu_wb_valid = (c >= 5 && c <= 9);
      bus.alu_wb_reg   = (c == 5) ? 5'd7 : 5'd8;
      bus.alu_wb_data  = (c == 5) ? 32'h0000_00A1 : 32'h0000_00B2;
      exp_rdy = !(c >= 6 && c <= 8);
      n_vec++;
      if (bus.alu_wb_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL burst_ready_c%0d: got %b want %b", c, bus.alu_wb_ready, exp_rdy);
      end
      step();
      exp_en = 1'b1;
      exp_rd = '0;
      exp_d  = '0;
      case (c)
        5: begin exp_rd = 5'd10; exp_d = 32'hC0DE_0005; end
        6: begin exp_rd = 5'd11; exp_d = 32'hC0DE_0006; end
        7: begin exp_rd = 5'd12; exp_d = 32'hC0DE_0007; end
        8: begin exp_rd = 5'd7;  exp_d = 32'h0000_00A1; end
        9: begin exp_rd = 5'd8;  exp_d = 32'h0000_00B2; end
        default: exp_en = 1'b0;
      endcase
      n_vec++;
      if (wr_en !== exp_en || (exp_en && (wr_reg !== exp_rd || wr_data !== exp_d))) begin
        n_err++;
        $display("FAIL burst_write_c%0d: got en=%b rd=%0d d=%h want en=%b rd=%0d d=%h",
                 c, wr_en, wr_reg, wr_data, exp_en, exp_rd, exp_d);
      end
    end
    idle();
    n_vec++;
    if (coll !== 3'd1) begin
      n_err++;
      $display("FAIL burst_coll: got %0d want 1", coll);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      bus.ex_valid     = (c == 0 || c == 3 || c == 4);
      bus.ex_wr_reg    = (c == 0) ? 5'd4 : RW'(10 + c);
      bus.mul_result   = 32'h0000_0044;
      bus.alu_wb_valid = (c == 5);
      bus.alu_wb_reg   = 5'd7;
      bus.alu_wb_data  = 32'h0000_0077;
      step();
    end
    idle();
    n_vec++;
    if ({ex_valid, wr_en, bus.alu_wb_ready} !== {4'b0110, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mid_pre: got v=%b en=%b rdy=%b want v=0110 en=1 rdy=0",
               ex_valid, wr_en, bus.alu_wb_ready);
    end
    #2;
    rst_i = 1'b0;
    #1;
    n_vec++;
    if ({ex_valid, wb_next, wr_en, wr_reg, wr_data, coll} !== '0 || ex_wr_reg !== '0) begin
      n_err++;
      $display("FAIL mid_async: got v=%b nx=%b en=%b rd=%0d d=%h cnt=%0d srd=%h want all 0",
               ex_valid, wb_next, wr_en, wr_reg, wr_data, coll, ex_wr_reg);
    end
    n_vec++;
    if (bus.alu_wb_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_ready: got %b want 1", bus.alu_wb_ready);
    end
    @(negedge clk);
    rst_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      n_vec++;
      if ({ex_valid, wb_next, wr_en} !== '0) begin
        n_err++;
        $display("FAIL mid_post_c%0d: got %b want 0", c, {ex_valid, wb_next, wr_en});
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      bus.ex_valid     = (c <= 16) && (c % 2 == 0);
      bus.ex_wr_reg    = RW'(1 + c / 2);
      bus.mul_result   = DW'(c);
      bus.alu_wb_valid = (c >= 5) && (c <= 21) && (c % 2 == 1);
      bus.alu_wb_reg   = 5'd20;
      bus.alu_wb_data  = DW'(c);
      step();
      if (c == 9) begin
        n_vec++;
        if (coll !== 3'd3) begin
          n_err++;
          $display("FAIL sat_mid: got %0d want 3", coll);
        end
      end
    end
    idle();
    n_vec++;
    if (coll !== 3'd7) begin
      n_err++;
      $display("FAIL sat_hold: got %0d want 7", coll);
    end
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_x0_mul();
    test_alu_direct();
    test_collision();
    test_back_to_back();
    test_reset_midflight();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_wb_scheduler.md
# mul_wb_scheduler

Sequences the fixed-latency multiply pipeline and schedules the single register-file write port between multiply results and ALU/memory results. It tracks per-stage valid/destination state for in-flight multiplies, feeds the decode hazard logic (`exN_valid`, `exN_wr_reg`, `wb_is_next_cycle`), and owns the writeback register. It sits between the execute/memory stages and the register file.

## Interface
- `DATA_WIDTH`, `params_pkg::DATA_WIDTH` (32): result width.
- `REGISTER_WIDTH`, `params_pkg::REGISTER_WIDTH` (5): register index width.
- `MUL_LATENCY`, `params_pkg::MUL_LATENCY` (5): number of multiply stages; must be at least 2.
- `COLL_CNT_WIDTH`, 16: width of the collision counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. One clock. Reset is asynchronous and active-low.
- `ex_valid_i`  in  1  a multiply is issued from decode this cycle.
- `ex_wr_reg_i`  in  REGISTER_WIDTH  destination of the issued multiply.
- `mul_result_i`  in  DATA_WIDTH  multiplier datapath output, aligned with the last stage.
- `alu_wb_valid_i`  in  1  an ALU/memory result requests writeback.
- `alu_wb_reg_i`  in  REGISTER_WIDTH  destination of that result.
- `alu_wb_data_i`  in  DATA_WIDTH  data of that result.
- `alu_wb_ready_o`  out  1  the ALU/memory result is accepted this cycle.
- `ex_valid_o`  out  MUL_LATENCY-1  stage 1..MUL_LATENCY-1 valid flags (bit k-1 = stage k).
- `ex_wr_reg_o`  out  (MUL_LATENCY-1)×REGISTER_WIDTH  stage destinations.
- `wb_is_next_cycle_o`  out  1  the last multiply stage is valid.
- `wb_reg_wr_en_o`  out  1  register-file write enable.
- `wb_wr_reg_o`  out  REGISTER_WIDTH  write index.
- `wb_data_o`  out  DATA_WIDTH  write data.
- `coll_cnt_o`  out  COLL_CNT_WIDTH  saturating count of cycles where a multiply result deferred an ALU result.

## Operation
- **Stage shift register:** each stage holds {valid, rd} and advances every cycle. It never stalls because the multiplier has fixed latency. Stage 1 loads `ex_valid_i && ex_wr_reg_i != 0`, so an x0 destination never creates a hazard.
- **Hold buffer:** one entry, holding {valid, rd, data}. `alu_wb_ready_o = !hold_valid`, taken from the registered flag only, so it has no combinational path to any input.
- **Per-cycle arbitration**, in fixed priority, among:
  1. the last multiply stage (MUL), using `mul_result_i`;
  2. the hold buffer (BUF);
  3. the incoming ALU result (ALU), only when `alu_wb_valid_i && alu_wb_ready_o`.
- **Winner:** loads the WB register at the edge, with `wb_reg_wr_en_o = 1` and `wb_wr_reg_o` / `wb_data_o` taken from the winner. When there is no candidate, `wb_reg_wr_en_o = 0` and index/data hold their previous values.
- **Deferred ALU result:** an ALU result accepted but not granted (MUL won) loads the hold buffer, and `coll_cnt_o` increments, saturating at all-ones. A BUF grant clears the hold buffer.
- **Ready low:** `alu_wb_valid_i` while `alu_wb_ready_o = 0` is ignored. The upstream holds its result and its stage stalls.
- **x0 destination:** an ALU result with rd = 0 is accepted and discarded: no write, no buffer load.
- **Reset:**
  - all stage valids, `hold_valid` and `wb_reg_wr_en_o` go to 0;
  - `wb_wr_reg_o`, `wb_data_o`, `coll_cnt_o` and stage rd fields go to 0;
  - `alu_wb_ready_o` is 1 and `wb_is_next_cycle_o` is 0.
  
  Reset mid-operation drops all in-flight multiplies and any buffered result, with no write.

## Timing
- Multiply latency:
  - issue sampled at edge e0 → stage k valid after edge e0+k-1;
  - `wb_is_next_cycle_o` is high in the cycle after e0+MUL_LATENCY-1;
  - `wb_reg_wr_en_o` is high for exactly one cycle after edge e0+MUL_LATENCY.
- Back-to-back issues produce back-to-back writes with no bubbles.
- ALU result granted directly: written one edge after acceptance.
- Deferred ALU result: written at the first edge with no valid last multiply stage; the bound is the length of the multiply burst.
- Steady state with simultaneous MUL + BUF + new ALU is impossible because ready is low while the buffer is full.
- Outputs `ex_valid_o`, `ex_wr_reg_o`, `wb_is_next_cycle_o` and `alu_wb_ready_o` are pure functions of registers.

## Structure
- Add to `params_pkg`:
  - `MUL_LATENCY`;
  - `typedef enum logic [1:0] {WB_NONE, WB_MUL, WB_BUF, WB_ALU} wb_src_e`;
  - `typedef struct packed {logic valid; logic [REGISTER_WIDTH-1:0] rd;} mul_stage_t`.
- One sub-module, `wb_hold_buffer`: the single-entry {valid, rd, data} register with load/clear and async reset.
- Arbitration is a combinational priority encoder producing `wb_src_e`.

## Test plan
- **Single multiply:** issue rd=5 at e0 with `mul_result_i`=0x1234 in the final stage → `ex_valid_o` walks bits 0..3 and `wb_is_next_cycle_o` asserts in the following cycle; write rd=5, 0x1234 after e0+5, exactly one write-enable cycle.
- **x0 multiply:** issue rd=0 → no stage valid, no write.
- **Collision:** ALU result (rd=7, 0xAAAA) offered in the same cycle the last multiply stage (rd=3) is valid → rd=3 written first, rd=7/0xAAAA written the next cycle; `alu_wb_ready_o` is 0 for one cycle; `coll_cnt_o` = 1.
- **Multiply burst vs buffer:** three back-to-back multiplies with an ALU collision on the first → three multiply writes, then the buffered ALU write; a second ALU request during the burst is held off by ready = 0 and is written last.
- **Reset mid-flight:** assert `rst_i`=0 asynchronously with two multiplies in flight and the buffer full → all outputs reach reset values before the next edge; no write after release.
- **Saturation:** force 2^16+3 collisions (or use a reduced `COLL_CNT_WIDTH`=2 with 5 collisions) → counter holds all-ones.
